// File: rtl/softmax_argmax.sv
// Top-1 classifier behind the softmax unit: sequential argmax scan
// with top-1/top-2 margin, low-confidence flag and valid/ready result.
module softmax_argmax #(
  parameter int                NUM_CLASSES = 10,
  parameter int                DATA_W      = 16,
  parameter int                IDX_W       = 4,
  parameter logic [DATA_W-1:0] CONF_THRESH = 16'h4000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CLASSES*DATA_W-1:0] prob_in,
  input  logic                          in_valid,
  output logic                          busy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [IDX_W-1:0]              class_idx,
  output logic [DATA_W-1:0]             max_prob,
  output logic [DATA_W-1:0]             margin,
  output logic                          low_conf,
  output logic [7:0]                    drop_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_OUT
  } state_e;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  state_e state_q, state_d;

  logic [NUM_CLASSES*DATA_W-1:0] vec_q;
  logic [DATA_W-1:0]             best_q, second_q;
  logic [IDX_W-1:0]              bidx_q, cnt_q;

  logic [IDX_W-1:0]  class_q;
  logic [DATA_W-1:0] max_q, margin_q;
  logic              low_q, valid_q;
  logic [7:0]        drop_q;

  logic [DATA_W-1:0] lane;
  logic [DATA_W-1:0] best_d, second_d;
  logic [IDX_W-1:0]  bidx_d;
  logic              last;

  // Vector shifts down one lane per scan cycle, so lane 0 is current
  assign lane = vec_q[DATA_W-1:0];
  assign last = (cnt_q == LAST);

  always_comb begin
    best_d   = best_q;
    second_d = second_q;
    bidx_d   = bidx_q;
    if (lane > best_q) begin
      best_d   = lane;
      second_d = best_q;
      bidx_d   = cnt_q;
    end else if (lane > second_q) begin
      second_d = lane;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (in_valid) state_d = S_SCAN;
      S_SCAN: if (last) state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q    <= '0;
      best_q   <= '0;
      second_q <= '0;
      bidx_q   <= '0;
      cnt_q    <= '0;
      class_q  <= '0;
      max_q    <= '0;
      margin_q <= '0;
      low_q    <= 1'b0;
      valid_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (in_valid && state_q != S_IDLE && drop_q != 8'hFF)
        drop_q <= drop_q + 8'd1;
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            vec_q    <= prob_in;
            best_q   <= '0;
            second_q <= '0;
            bidx_q   <= '0;
            cnt_q    <= '0;
          end
        end
        S_SCAN: begin
          vec_q    <= vec_q >> DATA_W;
          best_q   <= best_d;
          second_q <= second_d;
          bidx_q   <= bidx_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            class_q  <= bidx_d;
            max_q    <= best_d;
            margin_q <= best_d - second_d;
            low_q    <= (best_d < CONF_THRESH);
            valid_q  <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign out_valid  = valid_q;
  assign class_idx  = class_q;
  assign max_prob   = max_q;
  assign margin     = margin_q;
  assign low_conf   = low_q;
  assign drop_count = drop_q;

endmodule
